// File: rtl/fetch_pkg.sv
// Shared constants and types for the fetch_queue instruction-fetch front end.
package fetch_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef logic [0:0] fetch_state_t;
  localparam fetch_state_t StIdle = 1'b0;
  localparam fetch_state_t StRun  = 1'b1;

  localparam int unsigned DefPcWidth   = 10;
  localparam int unsigned DefDataWidth = 32;

  // Decode-side entry layout for the default configuration.
  typedef struct packed {
    logic [DefDataWidth-1:0] inst;
    logic [DefPcWidth-1:0]   pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with clear, occupancy count and full/empty flags.
module fetch_fifo #(
  parameter int unsigned Width = 42,
  parameter int unsigned Depth = 4,
  localparam int unsigned CntW = $clog2(Depth) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  input  logic             clear_i,
  output logic [Width-1:0] data_o,
  output logic [CntW-1:0]  count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !clear_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  push_no_overflow_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push_i && full_o && !pop_i && !clear_i));

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: in-order IM word fetches buffered in a prefetch FIFO for decode.
// Optional FETCH_STATS_EN adds saturating stat_stall / stat_drop counters.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned         PC_WIDTH   = 10,
  parameter int unsigned         DATA_WIDTH = 32,
  parameter int unsigned         DEPTH      = 4,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  enable,
  output logic                  im_req,
  output logic [PC_WIDTH-1:0]   im_addr,
  input  logic                  im_rvalid,
  input  logic [DATA_WIDTH-1:0] im_rdata,
  input  logic                  redirect_valid,
  input  logic [PC_WIDTH-1:0]   redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_inst,
  output logic [PC_WIDTH-1:0]   out_pc
`ifdef FETCH_STATS_EN
  ,
  output logic [15:0]           stat_stall,
  output logic [15:0]           stat_drop
`endif
);

  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned CntW   = PtrW + 1;
  localparam int unsigned SumW   = CntW + 1;
  localparam int unsigned EntryW = DATA_WIDTH + PC_WIDTH;

  fetch_state_t        state_q, state_d;
  logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [CntW-1:0]     outstanding_q, outstanding_d;
  logic [CntW-1:0]     drop_cnt_q, drop_cnt_d;
  logic [PC_WIDTH-1:0] tag_q [DEPTH];
  logic [PtrW-1:0]     tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;

  logic [CntW-1:0]     fifo_count;
  logic                fifo_full, fifo_empty;
  logic [EntryW-1:0]   fifo_head;
  logic                credit_ok, issue, rsp, push, pop;

  assign state_d   = enable ? StRun : StIdle;
  // Buffered plus in-flight words (including ones to be dropped) never exceed DEPTH.
  assign credit_ok = ({1'b0, fifo_count} + {1'b0, outstanding_q}) < SumW'(DEPTH);
  assign issue     = (state_q == StRun) && !redirect_valid && credit_ok;
  assign rsp       = im_rvalid && (outstanding_q != '0);
  assign push      = rsp && (drop_cnt_q == '0) && !redirect_valid && (!fifo_full || pop);
  assign pop       = out_valid && out_ready;

  always_comb begin
    outstanding_d = outstanding_q + CntW'(issue) - CntW'(rsp);
    drop_cnt_d    = drop_cnt_q;
    fetch_pc_d    = fetch_pc_q;
    tag_wr_d      = tag_wr_q;
    tag_rd_d      = tag_rd_q;
    if (redirect_valid) begin
      // Everything still in flight after this cycle's response belongs to the old path.
      drop_cnt_d = outstanding_q - CntW'(rsp);
      fetch_pc_d = redirect_pc;
      tag_wr_d   = '0;
      tag_rd_d   = '0;
    end else begin
      if (rsp && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CntW'(1);
      if (issue) begin
        fetch_pc_d = fetch_pc_q + PC_WIDTH'(1);
        tag_wr_d   = tag_wr_q + PtrW'(1);
      end
      if (push) tag_rd_d = tag_rd_q + PtrW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      tag_wr_q      <= '0;
      tag_rd_q      <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      tag_wr_q      <= tag_wr_d;
      tag_rd_q      <= tag_rd_d;
    end
  end

  always_ff @(posedge clock) begin
    if (issue) tag_q[tag_wr_q] <= fetch_pc_q;
  end

  fetch_fifo #(
    .Width (EntryW),
    .Depth (DEPTH)
  ) u_data_fifo (
    .clk_i   (clock),
    .rst_ni  (reset_n),
    .push_i  (push),
    .data_i  ({im_rdata, tag_q[tag_rd_q]}),
    .pop_i   (pop),
    .clear_i (redirect_valid),
    .data_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign im_req    = issue;
  assign im_addr   = fetch_pc_q;
  assign out_valid = !fifo_empty;
  assign out_inst  = out_valid ? fifo_head[EntryW-1 -: DATA_WIDTH] : DATA_WIDTH'(NOP_INST);
  assign out_pc    = out_valid ? fifo_head[PC_WIDTH-1:0] : '0;

`ifdef FETCH_STATS_EN
  logic [15:0] stall_q, drop_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= '0;
      drop_q  <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_q != '1)) stall_q <= stall_q + 16'd1;
      if (rsp && !push && (drop_q != '1))            drop_q  <= drop_q + 16'd1;
    end
  end

  assign stat_stall = stall_q;
  assign stat_drop  = drop_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus randomized traffic vs a stream model.
module tb_fetch_queue;
  import fetch_pkg::*;

  localparam int unsigned PW    = 10;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic          im_rvalid = 1'b0;
  logic [DW-1:0] im_rdata = '0;
  logic          redirect_valid = 1'b0;
  logic [PW-1:0] redirect_pc = '0;
  logic          out_ready = 1'b0;
  logic          im_req, out_valid;
  logic [PW-1:0] im_addr, out_pc;
  logic [DW-1:0] out_inst;
`ifdef FETCH_STATS_EN
  logic [15:0]   stat_stall, stat_drop;
`endif

  fetch_queue #(
    .PC_WIDTH   (PW),
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .RESET_PC   (10'h000)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .enable         (enable),
    .im_req         (im_req),
    .im_addr        (im_addr),
    .im_rvalid      (im_rvalid),
    .im_rdata       (im_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc)
`ifdef FETCH_STATS_EN
    ,
    .stat_stall     (stat_stall),
    .stat_drop      (stat_drop)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    int            due;
    logic [PW-1:0] addr;
  } mem_rsp_t;

  mem_rsp_t     memq[$];
  fetch_entry_t model_q[$];
  logic [PW-1:0] model_pc = '0;
  int cyc = 0;
  int last_due = -1;
  int lat = 1;
  int n_checks = 0;
  int n_pass = 0;

  logic          obs_req, obs_valid, head_ok;
  logic [PW-1:0] obs_addr, obs_pc, exp_addr;
  logic [DW-1:0] obs_inst;
  fetch_entry_t  head;

  function automatic logic [DW-1:0] mem_word(input logic [PW-1:0] a);
    return {6'h2A, a, ~a, 6'h15};
  endfunction

  // One clock: serve memory, sample outputs, advance the program-order model.
  task automatic step();
    mem_rsp_t r;
    int due;
    if (memq.size() != 0 && memq[0].due == cyc) begin
      r = memq.pop_front();
      im_rvalid = 1'b1;
      im_rdata  = mem_word(r.addr);
    end else begin
      im_rvalid = 1'b0;
      im_rdata  = $urandom();
    end
    #1;
    obs_req   = im_req;
    obs_addr  = im_addr;
    obs_valid = out_valid;
    obs_pc    = out_pc;
    obs_inst  = out_inst;
    head_ok   = (model_q.size() != 0);
    head      = head_ok ? model_q[0] : '0;
    exp_addr  = model_pc;
    if (reset_n) begin
      if (redirect_valid) begin
        model_q.delete();
        model_pc = redirect_pc;
      end else begin
        if (obs_valid && out_ready && head_ok) void'(model_q.pop_front());
        if (obs_req) begin
          model_q.push_back('{inst: mem_word(model_pc), pc: model_pc});
          model_pc = model_pc + PW'(1);
        end
      end
      if (obs_req) begin
        due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
        memq.push_back('{due: due, addr: obs_addr});
        last_due = due;
      end
    end
    @(posedge clock);
    cyc++;
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    enable = 1'b0;
    redirect_valid = 1'b0;
    out_ready = 1'b0;
    model_q.delete();
    model_pc = '0;
    step();
    for (int k = 0; k < 12; k++) if (memq.size() != 0) step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step();
    n_checks++; if (obs_req !== 1'b0) $display("FAIL reset_req: got %b want 0", obs_req); else n_pass++;
    n_checks++; if (obs_addr !== 10'h000) $display("FAIL reset_addr: got %h want 000", obs_addr); else n_pass++;
    n_checks++; if (obs_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", obs_valid); else n_pass++;
    n_checks++; if (obs_inst !== NOP) $display("FAIL reset_inst: got %h want %h", obs_inst, NOP); else n_pass++;
    n_checks++; if (obs_pc !== 10'h000) $display("FAIL reset_pc: got %h want 000", obs_pc); else n_pass++;
  endtask

  task automatic test_stream();
    do_reset();
    lat = 1; enable = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      n_checks++; if (obs_req !== (i >= 1)) $display("FAIL stream_req[%0d]: got %b", i, obs_req); else n_pass++;
      if (i >= 1) begin
        n_checks++; if (obs_addr !== PW'(i - 1)) $display("FAIL stream_addr[%0d]: got %h want %h", i, obs_addr, PW'(i - 1)); else n_pass++;
      end
      n_checks++; if (obs_valid !== (i >= 3)) $display("FAIL stream_valid[%0d]: got %b", i, obs_valid); else n_pass++;
      if (i >= 3) begin
        n_checks++; if (obs_pc !== PW'(i - 3)) $display("FAIL stream_pc[%0d]: got %h want %h", i, obs_pc, PW'(i - 3)); else n_pass++;
        n_checks++; if (obs_inst !== mem_word(PW'(i - 3))) $display("FAIL stream_inst[%0d]: got %h want %h", i, obs_inst, mem_word(PW'(i - 3))); else n_pass++;
      end
    end
  endtask

  task automatic test_stall();
    int nreq = 0;
    int got = 0;
    do_reset();
    lat = 1; enable = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (obs_req) nreq++;
      if (obs_valid) begin
        n_checks++; if (obs_pc !== 10'h000 || obs_inst !== mem_word(10'h000)) $display("FAIL stall_hold[%0d]: got %h/%h want 000/%h", i, obs_pc, obs_inst, mem_word(10'h000)); else n_pass++;
      end
    end
    n_checks++; if (nreq != 4) $display("FAIL stall_reqs: got %0d want 4", nreq); else n_pass++;
    n_checks++; if (obs_req !== 1'b0) $display("FAIL stall_req_off: got %b want 0", obs_req); else n_pass++;
`ifdef FETCH_STATS_EN
    n_checks++; if (stat_stall !== 16'd7) $display("FAIL stat_stall: got %0d want 7", stat_stall); else n_pass++;
`endif
    out_ready = 1'b1;
    for (int i = 0; i < 20 && got < 4; i++) begin
      step();
      if (obs_valid) begin
        n_checks++; if (obs_pc !== PW'(got) || obs_inst !== mem_word(PW'(got))) $display("FAIL stall_release[%0d]: got %h want %h", got, obs_pc, PW'(got)); else n_pass++;
        got++;
      end
    end
    n_checks++; if (got != 4) $display("FAIL stall_release_timeout: got %0d words want 4", got); else n_pass++;
  endtask

  task automatic test_redirect_inflight();
    int nreq = 0;
    do_reset();
    lat = 3; enable = 1'b1; out_ready = 1'b1; redirect_pc = 10'h100;
    for (int i = 0; i < 11; i++) begin
      redirect_valid = (i == 4);
      if (i == 4) begin
        n_checks++; if (nreq != 3) $display("FAIL redir_inflight: got %0d want 3", nreq); else n_pass++;
      end
      step();
      if (obs_req) nreq++;
      if (i == 4) begin
        n_checks++; if (obs_req !== 1'b0) $display("FAIL redir_req_blocked: got %b want 0", obs_req); else n_pass++;
      end
      if (i == 5) begin
        n_checks++; if (obs_req !== 1'b1 || obs_addr !== 10'h100) $display("FAIL redir_first_req: got %b/%h want 1/100", obs_req, obs_addr); else n_pass++;
      end
      if (i >= 5 && i <= 8) begin
        n_checks++; if (obs_valid !== 1'b0) $display("FAIL redir_drop_valid[%0d]: got %b want 0", i, obs_valid); else n_pass++;
      end
      if (i == 9) begin
        n_checks++; if (obs_valid !== 1'b1 || obs_pc !== 10'h100 || obs_inst !== mem_word(10'h100)) $display("FAIL redir_first_out: got %b/%h/%h want 1/100/%h", obs_valid, obs_pc, obs_inst, mem_word(10'h100)); else n_pass++;
      end
    end
    redirect_valid = 1'b0;
`ifdef FETCH_STATS_EN
    n_checks++; if (stat_drop !== 16'd3) $display("FAIL stat_drop: got %0d want 3", stat_drop); else n_pass++;
`endif
  endtask

  task automatic test_redirect_pop();
    do_reset();
    lat = 1; enable = 1'b1; out_ready = 1'b1; redirect_pc = 10'h200;
    for (int i = 0; i < 12; i++) begin
      redirect_valid = (i == 6);
      step();
      if (i == 6) begin
        n_checks++; if (obs_valid !== 1'b1 || obs_pc !== 10'h003) $display("FAIL rpop_popped: got %b/%h want 1/003", obs_valid, obs_pc); else n_pass++;
      end
      if (i == 7 || i == 8) begin
        n_checks++; if (obs_valid !== 1'b0) $display("FAIL rpop_valid_off[%0d]: got %b want 0", i, obs_valid); else n_pass++;
      end
      if (i >= 9) begin
        n_checks++; if (obs_valid !== 1'b1 || obs_pc !== PW'(10'h200 + i - 9)) $display("FAIL rpop_after[%0d]: got %b/%h want 1/%h", i, obs_valid, obs_pc, PW'(10'h200 + i - 9)); else n_pass++;
      end
    end
    redirect_valid = 1'b0;
  endtask

  task automatic test_wrap();
    logic [PW-1:0] want;
    do_reset();
    lat = 1; enable = 1'b1; out_ready = 1'b1; redirect_pc = 10'h3FE;
    for (int i = 0; i < 9; i++) begin
      redirect_valid = (i == 2);
      step();
      if (i >= 3 && i <= 5) begin
        want = PW'(10'h3FE + i - 3);
        n_checks++; if (obs_req !== 1'b1 || obs_addr !== want) $display("FAIL wrap_addr[%0d]: got %b/%h want 1/%h", i, obs_req, obs_addr, want); else n_pass++;
      end
      if (i >= 5 && i <= 7) begin
        want = PW'(10'h3FE + i - 5);
        n_checks++; if (obs_valid !== 1'b1 || obs_pc !== want) $display("FAIL wrap_out[%0d]: got %b/%h want 1/%h", i, obs_valid, obs_pc, want); else n_pass++;
      end
    end
    redirect_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    int i;
    do_reset();
    lat = 3; enable = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) step();
    reset_n = 1'b0;
    #1;
    n_checks++; if (im_req !== 1'b0 || im_addr !== 10'h000) $display("FAIL rmid_req: got %b/%h want 0/000", im_req, im_addr); else n_pass++;
    n_checks++; if (out_valid !== 1'b0 || out_inst !== NOP || out_pc !== 10'h000) $display("FAIL rmid_out: got %b/%h/%h", out_valid, out_inst, out_pc); else n_pass++;
    model_q.delete();
    model_pc = '0;
    enable = 1'b0;
    step();
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      n_checks++; if (obs_valid !== 1'b0) $display("FAIL rmid_stale[%0d]: got %b want 0", k, obs_valid); else n_pass++;
    end
    enable = 1'b1;
    i = 0;
    do begin step(); i++; end while (!obs_req && i < 6);
    n_checks++; if (obs_req !== 1'b1 || obs_addr !== 10'h000) $display("FAIL rmid_refetch: got %b/%h want 1/000", obs_req, obs_addr); else n_pass++;
    i = 0;
    do begin step(); i++; end while (!obs_valid && i < 8);
    n_checks++; if (obs_valid !== 1'b1 || obs_pc !== 10'h000 || obs_inst !== mem_word(10'h000)) $display("FAIL rmid_first_out: got %b/%h/%h", obs_valid, obs_pc, obs_inst); else n_pass++;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      enable         = ($urandom_range(0, 7) != 0);
      out_ready      = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = PW'($urandom());
      lat            = $urandom_range(1, 4);
      step();
      if (obs_valid) begin
        n_checks++;
        if (!head_ok) $display("FAIL rand_spurious[%0d]: got valid pc %h want no word", i, obs_pc);
        else if (obs_pc !== head.pc || obs_inst !== head.inst) $display("FAIL rand_word[%0d]: got %h/%h want %h/%h", i, obs_pc, obs_inst, head.pc, head.inst);
        else n_pass++;
      end
      if (obs_req) begin
        n_checks++; if (obs_addr !== exp_addr) $display("FAIL rand_addr[%0d]: got %h want %h", i, obs_addr, exp_addr); else n_pass++;
      end
      if (redirect_valid) begin
        n_checks++; if (obs_req !== 1'b0) $display("FAIL rand_redir_req[%0d]: got %b want 0", i, obs_req); else n_pass++;
      end
    end
    enable = 1'b0; redirect_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 20; i++) step();
    n_checks++; if (model_q.size() != 0 || obs_valid !== 1'b0) $display("FAIL rand_drain: got %0d words left valid=%b want 0/0", model_q.size(), obs_valid); else n_pass++;
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_stream();
    test_stall();
    test_redirect_inflight();
    test_redirect_pop();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
